// File: rtl/fdc_sd_arbiter.sv
// Round-robin merge of four floppy-drive SD block requests onto one host SD channel.
// One transfer in flight; host ack and write-back data are routed to the granted drive only.
module fdc_sd_arbiter #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [3:0][31:0] req_lba,
    input  logic [3:0]       req_rd,
    input  logic [3:0]       req_wr,
    output logic [3:0]       req_ack,
    input  logic [3:0][7:0]  req_buff_din,
    output logic [31:0]      sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    input  logic             sd_ack,
    output logic [7:0]       sd_buff_din,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  ptr_q;
    logic [1:0]  gidx_q;
    logic [31:0] sd_lba_q;
    logic        sd_rd_q;
    logic        sd_wr_q;
    logic [23:0] timer_q;
    logic        timeout_err_q;

    logic [3:0]  pend;
    logic [1:0]  gnt_idx_d;
    logic        gnt_vld_d;
    logic [1:0]  cand;

    assign pend = req_rd | req_wr;

    // Scan ptr+1, ptr+2, ptr+3, ptr; first pending drive wins.
    always_comb begin
        gnt_idx_d = '0;
        gnt_vld_d = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!gnt_vld_d && pend[cand]) begin
                gnt_vld_d = 1'b1;
                gnt_idx_d = cand;
            end
        end
    end

    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            ptr_q         <= 2'd3;
            gidx_q        <= '0;
            sd_lba_q      <= '0;
            sd_rd_q       <= 1'b0;
            sd_wr_q       <= 1'b0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        gidx_q   <= gnt_idx_d;
                        sd_lba_q <= req_lba[gnt_idx_d];
                        sd_rd_q  <= ~req_wr[gnt_idx_d];
                        sd_wr_q  <= req_wr[gnt_idx_d];
                        timer_q  <= '0;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sd_ack) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        state_q <= XFER;
                    end else if (!pend[gidx_q]) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        ptr_q   <= gidx_q;
                        state_q <= IDLE;
                    end else if (TIMEOUT_CYC != '0 && timer_q == TIMEOUT_CYC - 24'd1) begin
                        sd_rd_q       <= 1'b0;
                        sd_wr_q       <= 1'b0;
                        timeout_err_q <= 1'b1;
                        ptr_q         <= gidx_q;
                        state_q       <= IDLE;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + 24'd1;
                    end
                end
                XFER: begin
                    // Entered with sd_ack high, so a low level here is the falling edge.
                    if (!sd_ack) begin
                        ptr_q   <= gidx_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ack     = '0;
        sd_buff_din = '0;
        if (state_q == XFER) begin
            req_ack[gidx_q] = sd_ack;
            sd_buff_din     = req_buff_din[gidx_q];
        end
    end

    assign sd_lba      = sd_lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// Directed bench for fdc_sd_arbiter: single grant, round-robin order, write priority,
// timeout, requester withdrawal and asynchronous reset mid-transfer.
module tb_fdc_sd_arbiter;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic [3:0][31:0] req_lba;
    logic [3:0]       req_rd;
    logic [3:0]       req_wr;
    logic [3:0]       req_ack;
    logic [3:0][7:0]  req_buff_din;
    logic [31:0]      sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic             sd_ack;
    logic [7:0]       sd_buff_din;
    logic             busy;
    logic             timeout_err;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    fdc_sd_arbiter #(.TIMEOUT_CYC(24'd16)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .req_lba      (req_lba),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_ack      (req_ack),
        .req_buff_din (req_buff_din),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_din  (sd_buff_din),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // The DUT acts on negedge; sample and drive 1 time unit after posedge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_req();
        int unsigned n = 0;
        while (!(sd_rd || sd_wr) && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", 32'(sd_rd | sd_wr), 32'd1);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();
    endtask

    logic [3:0] onehot;
    int unsigned wr_cycles;
    int          exp_order [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        RESET_N      = 1'b0;
        req_rd       = '0;
        req_wr       = '0;
        sd_ack       = 1'b0;
        req_lba[0]   = 32'hA000_0000;
        req_lba[1]   = 32'h0000_1111;
        req_lba[2]   = 32'h0000_0123;
        req_lba[3]   = 32'h3333_3333;
        req_buff_din = '1;
        tick();
        check("rst_sd_rd", 32'(sd_rd), 32'd0);
        check("rst_sd_wr", 32'(sd_wr), 32'd0);
        check("rst_lba", sd_lba, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);
        RESET_N = 1'b1;
        tick();

        // Single read from drive 2, host acks for 10 cycles.
        req_rd = 4'b0100;
        tick();
        check("t1_sd_rd", 32'(sd_rd), 32'd1);
        check("t1_lba", sd_lba, 32'h123);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ack_issue", 32'(req_ack), 32'd0);
        sd_ack = 1'b1;
        tick();
        check("t1_rd_drop", 32'(sd_rd), 32'd0);
        req_rd = '0;
        for (int i = 0; i < 9; i++) begin
            check("t1_req_ack", 32'(req_ack), 32'b0100);
            check("t1_busy_x", 32'(busy), 32'd1);
            tick();
        end
        sd_ack = 1'b0;
        #1;
        check("t1_ack_low", 32'(req_ack), 32'd0);
        tick();
        check("t1_idle", 32'(busy), 32'd0);

        // Round-robin with all four requesting continuously.
        do_reset();
        req_rd = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            wait_req();
            check("rr_lba", sd_lba, req_lba[exp_order[g]]);
            sd_ack = 1'b1;
            tick();
            onehot = 4'b0001 << exp_order[g];
            check("rr_grant", 32'(req_ack), 32'(onehot));
            sd_ack = 1'b0;
            tick();
        end
        req_rd = '0;
        tick();
        tick();
        check("rr_idle", 32'(busy), 32'd0);

        // Drive 1 with both rd and wr: write wins, write-back byte routed.
        req_buff_din    = '1;
        req_buff_din[1] = 8'hA5;
        req_rd = 4'b0010;
        req_wr = 4'b0010;
        wait_req();
        check("wr_sd_wr", 32'(sd_wr), 32'd1);
        check("wr_sd_rd", 32'(sd_rd), 32'd0);
        check("wr_din_issue", 32'(sd_buff_din), 32'd0);
        sd_ack = 1'b1;
        tick();
        check("wr_din_xfer", 32'(sd_buff_din), 32'hA5);
        check("wr_req_ack", 32'(req_ack), 32'b0010);
        sd_ack = 1'b0;
        req_rd = '0;
        req_wr = '0;
        tick();
        check("wr_din_idle", 32'(sd_buff_din), 32'd0);
        check("wr_idle", 32'(busy), 32'd0);

        // Timeout: drive 3 write never acked.
        req_wr = 4'b1000;
        wait_req();
        wr_cycles = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!sd_wr) break;
            wr_cycles++;
            check("to_no_err", 32'(timeout_err), 32'd0);
        end
        check("to_wr_cycles", wr_cycles, 32'd16);
        check("to_err_pulse", 32'(timeout_err), 32'd1);
        check("to_idle", 32'(busy), 32'd0);
        tick();
        check("to_err_low", 32'(timeout_err), 32'd0);
        check("to_regrant", 32'(sd_wr), 32'd1);
        check("to_regrant_lba", sd_lba, req_lba[3]);
        req_wr = '0;
        tick();
        check("to_wd_wr", 32'(sd_wr), 32'd0);
        check("to_wd_busy", 32'(busy), 32'd0);

        // Withdrawal: drive 0 drops in ISSUE, drive 1 granted next.
        req_rd = 4'b0011;
        tick();
        check("wd_rd0", 32'(sd_rd), 32'd1);
        check("wd_lba0", sd_lba, req_lba[0]);
        req_rd = 4'b0010;
        tick();
        check("wd_rd_drop", 32'(sd_rd), 32'd0);
        check("wd_no_ack", 32'(req_ack), 32'd0);
        check("wd_busy", 32'(busy), 32'd0);
        tick();
        check("wd_rd1", 32'(sd_rd), 32'd1);
        check("wd_lba1", sd_lba, req_lba[1]);
        sd_ack = 1'b1;
        tick();
        check("wd_ack1", 32'(req_ack), 32'b0010);

        // Asynchronous reset during XFER.
        RESET_N = 1'b0;
        #1;
        check("ar_req_ack", 32'(req_ack), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_lba", sd_lba, 32'd0);
        check("ar_rd", 32'(sd_rd), 32'd0);
        sd_ack = 1'b0;
        req_rd = '0;
        tick();
        RESET_N = 1'b1;
        req_rd  = 4'b0101;
        wait_req();
        check("ar_first_lba", sd_lba, req_lba[0]);
        sd_ack = 1'b1;
        tick();
        check("ar_first_ack", 32'(req_ack), 32'b0001);
        sd_ack = 1'b0;
        req_rd = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
